// File: rtl/msp_ctrl_pkg.sv
// Shared types and constants for the MSP430-style multicycle control unit.
// Covers FSM states, opcode fields, ALU selects, jump conditions and flag positions.
package msp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OPC_ILLEGAL = 4'h0;
  localparam logic [3:0] OPC_SINGLE  = 4'h1;
  localparam logic [3:0] OPC_JMP_LO  = 4'h2;
  localparam logic [3:0] OPC_JMP_HI  = 4'h3;
  localparam logic [3:0] OPC_DBL_MIN = 4'h4;

  localparam logic [3:0] ALU_MOV  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_ADDC = 4'd2;
  localparam logic [3:0] ALU_SUBC = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd4;
  localparam logic [3:0] ALU_CMP  = 4'd5;
  localparam logic [3:0] ALU_DADD = 4'd6;
  localparam logic [3:0] ALU_BIT  = 4'd7;
  localparam logic [3:0] ALU_BIC  = 4'd8;
  localparam logic [3:0] ALU_BIS  = 4'd9;
  localparam logic [3:0] ALU_XOR  = 4'd10;
  localparam logic [3:0] ALU_AND  = 4'd11;
  localparam logic [3:0] ALU_RRC  = 4'd12;
  localparam logic [3:0] ALU_SWPB = 4'd13;
  localparam logic [3:0] ALU_RRA  = 4'd14;
  localparam logic [3:0] ALU_SXT  = 4'd15;

  localparam logic [2:0] JC_JNE = 3'b000;
  localparam logic [2:0] JC_JEQ = 3'b001;
  localparam logic [2:0] JC_JNC = 3'b010;
  localparam logic [2:0] JC_JC  = 3'b011;
  localparam logic [2:0] JC_JN  = 3'b100;
  localparam logic [2:0] JC_JGE = 3'b101;
  localparam logic [2:0] JC_JL  = 3'b110;
  localparam logic [2:0] JC_JMP = 3'b111;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/msp_jmp_cond.sv
// Jump condition evaluator: maps the 3-bit condition code and {V,N,Z,C}
// status flags to a branch-taken decision.
module msp_jmp_cond
  import msp_ctrl_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      JC_JNE: taken = ~flags[FLAG_Z];
      JC_JEQ: taken = flags[FLAG_Z];
      JC_JNC: taken = ~flags[FLAG_C];
      JC_JC:  taken = flags[FLAG_C];
      JC_JN:  taken = flags[FLAG_N];
      JC_JGE: taken = ~(flags[FLAG_N] ^ flags[FLAG_V]);
      JC_JL:  taken = flags[FLAG_N] ^ flags[FLAG_V];
      default: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/msp_ctrl_fsm.sv
// Multicycle control unit: fetch via valid/ack, decode the three instruction
// formats, then drive PC, register-file and ALU strobes one state at a time.
module msp_ctrl_fsm
  import msp_ctrl_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int REG_AW   = 4,
  parameter int OFF_W    = 10,
  parameter int ALU_OP_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  output logic                fetch_req,
  input  logic                instr_valid,
  input  logic [DATA_W-1:0]   instr_data,
  input  logic [3:0]          flags,
  output logic                pc_inc,
  output logic                pc_load,
  output logic [DATA_W-1:0]   pc_offset,
  output logic [REG_AW-1:0]   src_reg,
  output logic [REG_AW-1:0]   dst_reg,
  output logic [REG_AW-1:0]   wr_reg,
  output logic                wr_en,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                byte_op,
  output logic                flags_we,
  output logic [2:0]          state,
  output logic                illegal
);

  // Handshake: fetch_req is held high in FETCH; the first cycle that sees
  // instr_valid=1 completes the transfer. instr_valid is ignored elsewhere.

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   ir;
  logic [3:0]          opc;
  logic                dec_legal, dec_jump, dec_byte;
  logic [ALU_OP_W-1:0] dec_alu;
  logic [REG_AW-1:0]   dec_src, dec_dst;
  logic [2:0]          dec_cond;
  logic                jmp_taken;
  logic [DATA_W-1:0]   off_sext;

  assign opc      = ir[15:12];
  assign dec_cond = {ir[12], ir[11:10]};
  assign state    = state_q;

  always_comb begin
    dec_legal = 1'b0;
    dec_jump  = 1'b0;
    dec_byte  = 1'b0;
    dec_alu   = '0;
    dec_src   = '0;
    dec_dst   = '0;
    if (opc >= OPC_DBL_MIN) begin
      dec_alu   = ALU_OP_W'(opc - OPC_DBL_MIN);
      dec_src   = REG_AW'(ir[11:8]);
      dec_dst   = REG_AW'(ir[3:0]);
      dec_byte  = ir[6];
      // Only register-direct addressing on both operands is supported.
      dec_legal = ~ir[7] && (ir[5:4] == 2'b00);
    end else if (opc == OPC_SINGLE) begin
      dec_src   = REG_AW'(ir[3:0]);
      dec_dst   = REG_AW'(ir[3:0]);
      dec_byte  = ir[6];
      dec_alu   = ALU_OP_W'({2'b11, ir[8:7]});
      dec_legal = ~ir[9];
    end else if (opc == OPC_JMP_LO || opc == OPC_JMP_HI) begin
      dec_jump  = 1'b1;
      dec_legal = 1'b1;
    end
  end

  msp_jmp_cond u_jmp_cond (
    .cond  (dec_cond),
    .flags (flags),
    .taken (jmp_taken)
  );

  assign off_sext  = {{(DATA_W-OFF_W){ir[OFF_W-1]}}, ir[OFF_W-1:0]};
  assign pc_offset = {off_sext[DATA_W-2:0], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir      <= '0;
      src_reg <= '0;
      dst_reg <= '0;
      wr_reg  <= '0;
      alu_op  <= '0;
      byte_op <= 1'b0;
    end else begin
      if (state_q == ST_FETCH && instr_valid) ir <= instr_data;
      if (state_q == ST_DECODE) begin
        src_reg <= dec_src;
        dst_reg <= dec_dst;
        wr_reg  <= dec_dst;
        alu_op  <= dec_alu;
        byte_op <= dec_byte;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (instr_valid) state_d = ST_DECODE;
      ST_DECODE: state_d = dec_legal ? ST_EXEC : ST_HALT;
      ST_EXEC:   state_d = dec_jump ? ST_FETCH : ST_WB;
      ST_WB:     state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_HALT;
    endcase
  end

  always_comb begin
    fetch_req = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    flags_we  = 1'b0;
    wr_en     = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      // Gated by rst so every output reads 0 while reset is held.
      ST_FETCH:  fetch_req = ~rst;
      ST_DECODE: pc_inc = 1'b1;
      ST_EXEC: begin
        if (dec_jump) pc_load = jmp_taken;
        else flags_we = (alu_op != ALU_OP_W'(ALU_MOV))  &&
                        (alu_op != ALU_OP_W'(ALU_SWPB)) &&
                        (alu_op != ALU_OP_W'(ALU_SXT));
      end
      ST_WB: wr_en = (alu_op != ALU_OP_W'(ALU_CMP)) && (alu_op != ALU_OP_W'(ALU_BIT));
      ST_HALT: illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule
